stim_sweep_ctrl: RTL and testbench
==================================

Name: stim_sweep_ctrl

Overview:
Hardware stimulus sequencer for a unit under test whose inputs fall into three groups: a bundle of single-bit controls and two 32-bit operands. It walks each enabled group through an ascending count, one group at a time, and holds every other group at zero. Each vector is presented to a downstream sample/check stage through a valid/ready handshake. It is the synthesizable, clocked counterpart of the exhaustive per-group sweep that the generated benches perform.

Parameters:
W0, 8, width of group 0 (packed single-bit inputs, MSB = first-declared input)
W1, 32, width of group 1 (first wide operand)
W2, 32, width of group 2 (second wide operand)
SETTLE, 1, idle cycles between driving a vector and asserting smp_valid (0 allowed)
CNT_W, 32, vector counter width; W0, W1 and W2 must each be ≤ CNT_W

Ports:
clk  in  1  rising-edge clock, single clock domain
rst_n  in  1  asynchronous active-low reset
start  in  1  begin sweep; sampled only in IDLE
abort  in  1  terminate sweep; effective in any busy state
grp_en  in  3  per-group enable mask (bit g = group g), latched at start
limit  in  CNT_W  highest count per group, latched at start
stim_g0  out  W0  drive for group 0
stim_g1  out  W1  drive for group 1
stim_g2  out  W2  drive for group 2
smp_valid  out  1  current vector is settled and ready to sample
smp_ready  in  1  sample stage accepts the vector
grp_idx  out  2  group currently being swept
vec_idx  out  CNT_W  current count within the group
busy  out  1  sweep in progress
done  out  1  one-cycle pulse at the end of a sweep (normal or aborted)
aborted  out  1  last sweep ended by abort; cleared at next accepted start

Behaviour:
- Reset (async, rst_n=0): state IDLE; all stim, smp_valid, busy, done, aborted, grp_idx and vec_idx = 0.
- States: IDLE, SETTLE, SAMPLE, DONE.
- Per-group terminal count: last_g = min(limit, 2^Wg − 1). The counter never wraps.
- IDLE, start=1, grp_en≠0:
  - Latch grp_en and limit; clear aborted.
  - grp_idx = lowest enabled group; vec_idx = 0; all stim = 0; busy = 1.
  - Go to SETTLE, or straight to SAMPLE if SETTLE = 0.
- IDLE, start=1, grp_en=0: go to DONE. busy stays 0 and smp_valid is never asserted.
- SETTLE: hold all outputs for exactly SETTLE cycles, then go to SAMPLE.
- SAMPLE:
  - smp_valid = 1. stim, grp_idx and vec_idx stay stable until smp_valid & smp_ready.
  - On a handshake edge, vec_idx < last_g: vec_idx+1; active stim = vec_idx+1 (zero-extended/truncated to Wg); smp_valid drops; go to SETTLE. With SETTLE = 0, stay in SAMPLE so vectors issue back-to-back.
  - On a handshake edge, vec_idx = last_g, another enabled group remains: zero the finished group's stim; grp_idx = next higher enabled group; vec_idx = 0; go to SETTLE (or SAMPLE if SETTLE = 0).
  - On a handshake edge, vec_idx = last_g, no enabled group remains: go to DONE.
- DONE: done = 1 for one cycle; all stim = 0; busy = 0; smp_valid = 0; go to IDLE.
- Latency:
  - Edge that accepts start to smp_valid high = SETTLE+1 edges.
  - Between vectors, smp_valid is low for exactly SETTLE cycles.
  - Last handshake to done pulse = 1 edge.
- start while busy: ignored, with no effect on latched config.
- abort while busy: next edge goes to DONE with aborted = 1; stim forced to 0 in the same edge.
- abort and handshake in the same cycle: abort wins. The vector counts as accepted but no further vector is issued.
- Reset mid-sweep: immediate return to the reset values. No done pulse.
- Total handshakes per sweep = Σ over enabled g of (last_g + 1).

Test Plan:
- grp_en=001, limit=3, SETTLE=1, ready tied 1 -> stim_g0 = 0,1,2,3; each smp_valid high 1 cycle with 1 low cycle between; done pulses 1 edge after the 4th handshake; stim_g0 returns to 0.
- grp_en=111, limit=2 -> 9 handshakes: g0 0..2, g1 0..2, g2 0..2; grp_idx 0,1,2; the two inactive stim buses read 0 at every handshake.
- grp_en=101, limit=300, W0=8 -> g0 sweeps 0..255 (256 handshakes), group 1 skipped, then g2 0..300; total 557 handshakes.
- Backpressure: smp_ready low 5 cycles at vec_idx=7 -> smp_valid, stim and vec_idx held for 5 cycles; vec 8 follows the accept after SETTLE cycles.
- abort at grp_idx=1, vec_idx=5 -> next edge: stim all 0, busy 0, done pulse, aborted=1; next start clears aborted.
- rst_n low during SAMPLE -> all outputs 0 asynchronously, no done pulse. Separately: start with busy=1 is ignored; grp_en=000 gives a done pulse with no smp_valid.

Source files
------------

// File: rtl/stim_sweep_ctrl.sv
// rtl/stim_sweep_ctrl.sv - per-group ascending stimulus sweep with settle delay and sample handshake
module stim_sweep_ctrl #(
  parameter int W0     = 8,
  parameter int W1     = 32,
  parameter int W2     = 32,
  parameter int SETTLE = 1,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [2:0]       grp_en,
  input  logic [CNT_W-1:0] limit,
  output logic [W0-1:0]    stim_g0,
  output logic [W1-1:0]    stim_g1,
  output logic [W2-1:0]    stim_g2,
  output logic             smp_valid,
  input  logic             smp_ready,
  output logic [1:0]       grp_idx,
  output logic [CNT_W-1:0] vec_idx,
  output logic             busy,
  output logic             done,
  output logic             aborted
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_SAMPLE = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [1:0]       S_ENTRY     = (SETTLE == 0) ? S_SAMPLE : S_SETTLE;
  localparam logic [31:0]      SETTLE_LAST = (SETTLE > 0) ? 32'(SETTLE - 1) : 32'd0;
  localparam logic [CNT_W-1:0] MAX0 = {CNT_W{1'b1}} >> (CNT_W - W0);
  localparam logic [CNT_W-1:0] MAX1 = {CNT_W{1'b1}} >> (CNT_W - W1);
  localparam logic [CNT_W-1:0] MAX2 = {CNT_W{1'b1}} >> (CNT_W - W2);

  logic [1:0]       state_q, state_d;
  logic [2:0]       en_q, en_d;
  logic [CNT_W-1:0] limit_q, limit_d;
  logic [1:0]       grp_q, grp_d;
  logic [CNT_W-1:0] vec_q, vec_d;
  logic [W0-1:0]    s0_q, s0_d;
  logic [W1-1:0]    s1_q, s1_d;
  logic [W2-1:0]    s2_q, s2_d;
  logic [31:0]      cnt_q, cnt_d;
  logic             aborted_q, aborted_d;

  logic [CNT_W-1:0] cap_max, last_v, nxt_vec;
  logic [1:0]       first_grp, nxt_grp;
  logic             has_nxt;

  always_comb begin
    cap_max = (grp_q == 2'd0) ? MAX0 : (grp_q == 2'd1) ? MAX1 : MAX2;
    last_v  = (limit_q < cap_max) ? limit_q : cap_max;
    nxt_vec = vec_q + 1'b1;

    first_grp = grp_en[0] ? 2'd0 : (grp_en[1] ? 2'd1 : 2'd2);
    has_nxt   = 1'b0;
    nxt_grp   = grp_q;
    case (grp_q)
      2'd0: begin
        if (en_q[1]) begin
          has_nxt = 1'b1;
          nxt_grp = 2'd1;
        end else if (en_q[2]) begin
          has_nxt = 1'b1;
          nxt_grp = 2'd2;
        end
      end
      2'd1: begin
        if (en_q[2]) begin
          has_nxt = 1'b1;
          nxt_grp = 2'd2;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    en_d      = en_q;
    limit_d   = limit_q;
    grp_d     = grp_q;
    vec_d     = vec_q;
    s0_d      = s0_q;
    s1_d      = s1_q;
    s2_d      = s2_q;
    cnt_d     = cnt_q;
    aborted_d = aborted_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (grp_en != 3'b000) begin
            en_d      = grp_en;
            limit_d   = limit;
            aborted_d = 1'b0;
            grp_d     = first_grp;
            vec_d     = '0;
            s0_d      = '0;
            s1_d      = '0;
            s2_d      = '0;
            cnt_d     = '0;
            state_d   = S_ENTRY;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_SETTLE: begin
        if (abort) begin
          state_d   = S_DONE;
          aborted_d = 1'b1;
          s0_d = '0;
          s1_d = '0;
          s2_d = '0;
        end else if (cnt_q == SETTLE_LAST) begin
          state_d = S_SAMPLE;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_SAMPLE: begin
        // abort takes priority over a coincident handshake
        if (abort) begin
          state_d   = S_DONE;
          aborted_d = 1'b1;
          s0_d = '0;
          s1_d = '0;
          s2_d = '0;
        end else if (smp_ready) begin
          cnt_d = '0;
          if (vec_q < last_v) begin
            vec_d   = nxt_vec;
            state_d = S_ENTRY;
            case (grp_q)
              2'd0:    s0_d = nxt_vec[W0-1:0];
              2'd1:    s1_d = nxt_vec[W1-1:0];
              default: s2_d = nxt_vec[W2-1:0];
            endcase
          end else begin
            s0_d = '0;
            s1_d = '0;
            s2_d = '0;
            if (has_nxt) begin
              grp_d   = nxt_grp;
              vec_d   = '0;
              state_d = S_ENTRY;
            end else begin
              state_d = S_DONE;
            end
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      en_q      <= '0;
      limit_q   <= '0;
      grp_q     <= '0;
      vec_q     <= '0;
      s0_q      <= '0;
      s1_q      <= '0;
      s2_q      <= '0;
      cnt_q     <= '0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      en_q      <= en_d;
      limit_q   <= limit_d;
      grp_q     <= grp_d;
      vec_q     <= vec_d;
      s0_q      <= s0_d;
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      cnt_q     <= cnt_d;
      aborted_q <= aborted_d;
    end
  end

  assign stim_g0   = s0_q;
  assign stim_g1   = s1_q;
  assign stim_g2   = s2_q;
  assign grp_idx   = grp_q;
  assign vec_idx   = vec_q;
  assign aborted   = aborted_q;
  assign smp_valid = (state_q == S_SAMPLE);
  assign busy      = (state_q == S_SETTLE) || (state_q == S_SAMPLE);
  assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_stim_sweep_ctrl.sv
// tb/tb_stim_sweep_ctrl.sv - scoreboard bench for stim_sweep_ctrl with default parameters
module tb_stim_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [2:0]  grp_en;
  logic [31:0] limit;
  logic [7:0]  stim_g0;
  logic [31:0] stim_g1;
  logic [31:0] stim_g2;
  logic        smp_valid;
  logic        smp_ready;
  logic [1:0]  grp_idx;
  logic [31:0] vec_idx;
  logic        busy;
  logic        done;
  logic        aborted;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          g;
    logic [31:0] v;
    logic [7:0]  s0;
    logic [31:0] s1;
    logic [31:0] s2;
  } vec_t;

  vec_t sb[$];

  always #5 clk = ~clk;

  stim_sweep_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .grp_en(grp_en), .limit(limit),
    .stim_g0(stim_g0), .stim_g1(stim_g1), .stim_g2(stim_g2),
    .smp_valid(smp_valid), .smp_ready(smp_ready),
    .grp_idx(grp_idx), .vec_idx(vec_idx),
    .busy(busy), .done(done), .aborted(aborted)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_sweep(input logic [2:0] en, input logic [31:0] lim);
    vec_t e;
    longint mx, last;
    for (int g = 0; g < 3; g++) begin
      if (en[g]) begin
        mx   = (g == 0) ? 64'd255 : 64'hffff_ffff;
        last = (longint'(lim) < mx) ? longint'(lim) : mx;
        for (longint v = 0; v <= last; v++) begin
          e.g  = g;
          e.v  = 32'(v);
          e.s0 = (g == 0) ? 8'(v) : 8'd0;
          e.s1 = (g == 1) ? 32'(v) : 32'd0;
          e.s2 = (g == 2) ? 32'(v) : 32'd0;
          sb.push_back(e);
        end
      end
    end
  endtask

  task automatic run_sweep(input logic [2:0] en, input logic [31:0] lim, input int stall_v,
                           input int abort_g, input int abort_v, input int busy_start_v);
    vec_t e;
    int   exp_hs, hs, gap, stall;
    bit   aborting, done_seen, busy_started, gap_checked, expect_done;
    hs = 0; gap = 0; stall = 5;
    aborting = 0; done_seen = 0; busy_started = 0; gap_checked = 0; expect_done = 0;
    sb.delete();
    push_sweep(en, lim);
    exp_hs = sb.size();

    @(negedge clk);
    start = 1'b1; grp_en = en; limit = lim; smp_ready = 1'b1;
    @(negedge clk);
    chk("busy_after_start", {31'd0, busy}, {31'd0, en != 3'b000});
    if (en != 3'b000) chk("aborted_cleared", {31'd0, aborted}, 32'd0);

    for (int cyc = 0; cyc < 5000 && !done_seen; cyc++) begin
      start = 1'b0; abort = 1'b0; grp_en = 3'b000; limit = 32'd0;
      if (expect_done) begin
        chk("done_latency", {31'd0, done}, 32'd1);
        expect_done = 0;
      end
      if (done) begin
        done_seen = 1;
        chk("done_stim_g0", {24'd0, stim_g0}, 32'd0);
        chk("done_stim_g1", stim_g1, 32'd0);
        chk("done_stim_g2", stim_g2, 32'd0);
        chk("done_busy", {31'd0, busy}, 32'd0);
        chk("done_valid", {31'd0, smp_valid}, 32'd0);
        chk("done_aborted", {31'd0, aborted}, {31'd0, aborting});
        if (!aborting) chk("hs_total", hs, exp_hs);
        chk("sb_empty", sb.size(), 32'd0);
      end else if (smp_valid) begin
        chk("vec_avail", {31'd0, sb.size() > 0}, 32'd1);
        if (sb.size() > 0) begin
          e = sb[0];
          chk("grp_idx", {30'd0, grp_idx}, 32'(e.g));
          chk("vec_idx", vec_idx, e.v);
          chk("stim_g0", {24'd0, stim_g0}, {24'd0, e.s0});
          chk("stim_g1", stim_g1, e.s1);
          chk("stim_g2", stim_g2, e.s2);
          chk("busy_sample", {31'd0, busy}, 32'd1);
          if (!gap_checked) begin
            chk("settle_gap", gap, 32'd1);
            gap_checked = 1;
          end
          smp_ready = 1'b1;
          if (stall_v >= 0 && e.v == 32'(stall_v) && stall > 0) begin
            smp_ready = 1'b0;
            stall--;
          end
          if (busy_start_v >= 0 && e.v == 32'(busy_start_v) && !busy_started) begin
            start = 1'b1; grp_en = 3'b110; limit = 32'd0;
            smp_ready = 1'b0;
            busy_started = 1;
          end
          if (abort_g >= 0 && e.g == abort_g && e.v == 32'(abort_v)) begin
            abort = 1'b1;
            smp_ready = 1'b1;
            aborting = 1;
          end
          if (smp_ready) begin
            hs++;
            void'(sb.pop_front());
            gap = 0;
            gap_checked = 0;
            if (aborting) sb.delete();
            if (sb.size() == 0) expect_done = 1;
          end
        end
      end else begin
        gap++;
      end
      @(negedge clk);
    end
    start = 1'b0; abort = 1'b0; grp_en = 3'b000; limit = 32'd0;
    chk("sweep_timeout", {31'd0, done_seen}, 32'd1);
    chk("done_one_cycle", {31'd0, done}, 32'd0);
    chk("idle_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; grp_en = 3'b000; limit = 32'd0; smp_ready = 1'b0;
    #2;
    chk("rst_stim_g0", {24'd0, stim_g0}, 32'd0);
    chk("rst_stim_g1", stim_g1, 32'd0);
    chk("rst_stim_g2", stim_g2, 32'd0);
    chk("rst_ctrl", {27'd0, smp_valid, busy, done, aborted, 1'b0}, 32'd0);
    chk("rst_idx", {grp_idx, vec_idx[29:0]}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_sweep(3'b001, 32'd3, -1, -1, 0, -1);
    run_sweep(3'b111, 32'd2, -1, -1, 0, -1);
    run_sweep(3'b101, 32'd300, -1, -1, 0, -1);
    run_sweep(3'b001, 32'd20, 7, -1, 0, -1);
    run_sweep(3'b011, 32'd10, -1, 1, 5, -1);
    run_sweep(3'b001, 32'd3, -1, -1, 0, 1);
    run_sweep(3'b000, 32'd5, -1, -1, 0, -1);

    @(negedge clk);
    start = 1'b1; grp_en = 3'b111; limit = 32'd5; smp_ready = 1'b0;
    @(negedge clk);
    start = 1'b0; grp_en = 3'b000; limit = 32'd0;
    repeat (3) @(negedge clk);
    chk("pre_reset_valid", {31'd0, smp_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {31'd0, smp_valid}, 32'd0);
    chk("async_rst_busy", {31'd0, busy}, 32'd0);
    chk("async_rst_done", {31'd0, done}, 32'd0);
    chk("async_rst_stim_g0", {24'd0, stim_g0}, 32'd0);
    chk("async_rst_idx", {grp_idx, vec_idx[29:0]}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("no_done_after_reset", {31'd0, done}, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
